// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, address slicing, FSM state codes and
// the access-legality check used by the register memory.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  // PADDR[31] selects the completer in the bridge; the word index starts at bit 2.
  localparam int unsigned APB_SEL_BIT  = 31;
  localparam int unsigned APB_WORD_LSB = 2;

  // Completer FSM state codes.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  // Legal when word aligned and the word index falls inside the memory.
  function automatic logic addr_legal(input logic [APB_SEL_BIT-1:0] addr,
                                      input int unsigned depth);
    logic [31:0] idx;
    idx = {3'b000, addr[APB_SEL_BIT-1:APB_WORD_LSB]};
    return (addr[APB_WORD_LSB-1:0] == '0) && (idx < depth);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// 4-bit loadable down-counter pacing the ENABLE-phase wait states.
// done flags the last wait cycle (count of 1).
module apb_wait_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  // Load on SETUP, count down while waiting, never wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd1);

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed, byte-strobed register memory.
// Optional wait states are built only when APB_SLAVE_WAIT_STATES_EN is defined;
// otherwise every transfer completes in its first ENABLE cycle.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  output logic                  PREADY,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [1:0]            state;
  logic [APB_ADDR_W-1:0] addr_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] mem [DEPTH];

  logic                  setup;
  logic                  enter_ready;
  logic                  do_write;
  logic [APB_ADDR_W-1:0] cur_addr;
  logic                  cur_write;
  logic                  cur_legal;
  logic [IdxW-1:0]       cur_idx;
  logic                  unused_sel;

  assign setup = PSEL && !PENABLE;

`ifdef APB_SLAVE_WAIT_STATES_EN
  localparam logic [3:0] W = 4'(WAIT_CYCLES);
  logic wait_done;

  apb_wait_ctr u_wait_ctr (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     ((state == StIdle) && setup),
    .load_val (W),
    .dec      ((state == StWait) && PSEL),
    .done     (wait_done)
  );
`else
  localparam logic [3:0] W = 4'd0;
  localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
`endif

  // In IDLE the transfer is still on the bus; afterwards it lives in the latches.
  always_comb begin
    cur_addr  = (state == StIdle) ? PADDR  : addr_q;
    cur_write = (state == StIdle) ? PWRITE : write_q;
    cur_legal = addr_legal(cur_addr[APB_SEL_BIT-1:0], DEPTH);
    cur_idx   = cur_addr[APB_WORD_LSB +: IdxW];
    enter_ready = (state == StIdle) && setup && (W == 4'd0);
`ifdef APB_SLAVE_WAIT_STATES_EN
    enter_ready = enter_ready || ((state == StWait) && PSEL && wait_done);
`endif
    do_write = (state == StReady) && PSEL && PENABLE && write_q && cur_legal;
  end

  assign unused_sel = cur_addr[APB_SEL_BIT];

  // Handshake FSM, transfer latches and registered response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            state   <= (W == 4'd0) ? StReady : StWait;
          end
        end
`ifdef APB_SLAVE_WAIT_STATES_EN
        StWait: begin
          if (!PSEL) begin
            state <= StIdle;
          end else if (wait_done) begin
            state <= StReady;
          end
        end
`endif
        StReady: begin
          // Completion (PENABLE high) and abort (PSEL low) both retire the transfer.
          if (!PSEL || PENABLE) begin
            state   <= StIdle;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase

      if (enter_ready) begin
        PREADY  <= 1'b1;
        PSLVERR <= !cur_legal;
        PRDATA  <= (cur_legal && !cur_write) ? mem[cur_idx] : '0;
      end
    end
  end

  // Register memory: cleared on reset, byte-lane writes at the completing edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (strb_q[b]) begin
          mem[cur_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
